test_basic23_sink: RTL
======================

TEST_BASIC23_SINK -- requirements
Module: test_basic23_sink

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of the completed-pair counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous and active-low (asserted when 0, sampled on the clk rising edge).
REQ-004 SHALL have port: b_in  input  32  unsigned data from the unsigned blocking producer port.
REQ-005 SHALL have port: b_in_sync  input  1  producer has valid b_in this cycle.
REQ-006 SHALL have port: b_in_notify  output  1  sink ready to take b_in.
REQ-007 SHALL have port: b_in2  input  32  signed (two's complement) data from the signed blocking producer port.
REQ-008 SHALL have port: b_in2_sync  input  1  producer has valid b_in2 this cycle.
REQ-009 SHALL have port: b_in2_notify  output  1  sink ready to take b_in2.
REQ-010 SHALL have port: sum_out  output  32  signed result of the last completed pair.
REQ-011 SHALL have port: pair_cnt  output  CNT_W  number of completed pairs, saturating.
REQ-012 SHALL have port: pair_valid  output  1  high for exactly one cycle after each pair completes.

Function
REQ-013 SHALL implement a two-state machine: section_a (receive b_in) and section_b (receive b_in2).
REQ-014 In section_a, b_in_notify SHALL be 1 and b_in2_notify 0; in section_b, the reverse. Both are registered outputs.
REQ-015 Transfer SHALL occur on a rising edge where the active notify = 1 and the matching sync = 1.
REQ-016 On a section_a transfer: capture b_in into val_unsigned_signal; go to section_b; next cycle b_in_notify=0 and b_in2_notify=1.
REQ-017 On a section_b transfer: capture b_in2 into val_signed_signal; go to section_a; next cycle b_in2_notify=0 and b_in_notify=1.
REQ-018 On a section_b transfer, sum_out SHALL become val_unsigned_signal + b_in2, computed mod 2^32 and read as signed; wrap-around is silent.
REQ-019 On a section_b transfer, pair_cnt SHALL increment by 1, saturating at 2^CNT_W-1; pair_valid SHALL be 1 in the following cycle only.
REQ-020 When the matching sync is 0, the state, the notifies and the captured values SHALL hold.
REQ-021 A sync on the inactive port SHALL be ignored, including when both syncs are 1 in the same cycle.
REQ-022 Data on the inactive port SHALL NOT be sampled.
REQ-023 Throughput SHALL be at most one transfer per cycle: a pair takes a minimum of 2 cycles when sync is held high.

Reset
REQ-024 When rst=0 at a clk edge, the following SHALL be set:
  - section = section_a
  - val_signed_signal = -7, val_unsigned_signal = 13
  - b_in_notify = 1, b_in2_notify = 0
  - sum_out = 0, pair_cnt = 0, pair_valid = 0
REQ-025 Reset asserted mid-pair (in section_b) SHALL abandon the partial pair: no sum update and no count increment.
REQ-026 A sync arriving in the reset cycle SHALL NOT cause a transfer.

Structure
REQ-027 The enum TestBasic23_SECTIONS {section_a, section_b} SHALL live in the shared package testbasic23_types and be imported, not redeclared.
REQ-028 The reset constants -7 and 13 SHALL be package constants shared with the producer.
REQ-029 The design SHALL be a single module with one registered always block; no sub-module is required.

Verification
REQ-030 Release reset with both syncs 0 -> b_in_notify=1, b_in2_notify=0, sum_out=0, pair_cnt=0, held indefinitely.
REQ-031 b_in=13 with sync, then b_in2=-7 with sync on the next cycle -> sum_out=6, pair_cnt=1, pair_valid pulses 1 cycle; notifies alternate 1/0, 0/1, 1/0.
REQ-032 b_in=0xFFFFFFFF, then b_in2=2 -> sum_out=1 (wrap), no error indication.
REQ-033 b_in2_sync=1 while in section_a, and both syncs high in one cycle -> only b_in is taken; b_in2 is taken only after the transition to section_b.
REQ-034 Run 300 back-to-back pairs -> pair_cnt stops at 255; sum_out equals the last pair's sum.
REQ-035 Complete a b_in transfer, assert rst=0 for one cycle, then complete a full pair -> pair_cnt=1, and the sum uses the post-reset b_in only.

Source files
------------

// File: rtl/testbasic23_types.sv
// Shared types and reset constants for the basic23 producer/sink pair.
// Both sides import this so the section encoding and reset values never drift apart.
package testbasic23_types;

   typedef enum logic {
      section_a = 1'b0,
      section_b = 1'b1
   } TestBasic23_SECTIONS;

   localparam logic signed [31:0] VAL_SIGNED_RST   = -32'sd7;
   localparam logic        [31:0] VAL_UNSIGNED_RST = 32'd13;

endpackage

// File: rtl/test_basic23_sink.sv
// Alternating two-port sink: takes b_in, then b_in2, and emits their 32-bit wrapped sum; one
// transfer per cycle, a pair takes 2+ cycles; each port is backpressured by its registered notify.
module test_basic23_sink
   import testbasic23_types::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic        [31:0]      b_in,
   input  logic                    b_in_sync,
   output logic                    b_in_notify,
   input  logic signed [31:0]      b_in2,
   input  logic                    b_in2_sync,
   output logic                    b_in2_notify,
   output logic signed [31:0]      sum_out,
   output logic        [CNT_W-1:0] pair_cnt,
   output logic                    pair_valid
);

   TestBasic23_SECTIONS      section_q;
   logic        [31:0]       val_unsigned_q;
   logic signed [31:0]       val_signed_q;
   logic                     b_in_notify_q;
   logic                     b_in2_notify_q;
   logic signed [31:0]       sum_q;
   logic        [CNT_W-1:0]  pair_cnt_q;
   logic                     pair_valid_q;

   // The signed capture is architectural state kept for the producer's protocol, not consumed here.
   logic unused_val_signed;
   assign unused_val_signed = ^val_signed_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         section_q      <= section_a;
         val_signed_q   <= VAL_SIGNED_RST;
         val_unsigned_q <= VAL_UNSIGNED_RST;
         b_in_notify_q  <= 1'b1;
         b_in2_notify_q <= 1'b0;
         sum_q          <= '0;
         pair_cnt_q     <= '0;
         pair_valid_q   <= 1'b0;
      end else begin
         pair_valid_q <= 1'b0;
         case (section_q)
            section_a: begin
               if (b_in_notify_q && b_in_sync) begin
                  val_unsigned_q <= b_in;
                  section_q      <= section_b;
                  b_in_notify_q  <= 1'b0;
                  b_in2_notify_q <= 1'b1;
               end
            end
            section_b: begin
               if (b_in2_notify_q && b_in2_sync) begin
                  val_signed_q   <= b_in2;
                  sum_q          <= $signed(val_unsigned_q + $unsigned(b_in2));
                  if (pair_cnt_q != {CNT_W{1'b1}}) begin
                     pair_cnt_q <= pair_cnt_q + 1'b1;
                  end
                  pair_valid_q   <= 1'b1;
                  section_q      <= section_a;
                  b_in_notify_q  <= 1'b1;
                  b_in2_notify_q <= 1'b0;
               end
            end
            default: section_q <= section_a;
         endcase
      end
   end

   assign b_in_notify  = b_in_notify_q;
   assign b_in2_notify = b_in2_notify_q;
   assign sum_out      = sum_q;
   assign pair_cnt     = pair_cnt_q;
   assign pair_valid   = pair_valid_q;

endmodule
